// File: rtl/tm1638_responder.sv
// Target side of the TM1638 LED&KEY link: oversamples STB/CLK/DIO, decodes
// commands into a 16-byte display RAM and shifts key-scan bytes back on reads.
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lk_clk,
  input  logic        lk_stb,
  input  logic        lk_dio_i,
  output logic        lk_dio_o,
  output logic        lk_dio_oe,
  input  logic [31:0] keys,
  input  logic [3:0]  disp_addr,
  output logic [7:0]  disp_data,
  output logic        disp_on,
  output logic [2:0]  brightness,
  output logic        frame_done,
  output logic        cmd_err
);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, HOLD} state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] clk_sync, stb_sync, dio_sync;
  logic clk_q, stb_q;
  logic clk_s, stb_s, dio_s;
  logic clk_rise, clk_fall, stb_rise, stb_fall;

  logic [4:0]  bit_cnt;
  logic [6:0]  shreg;
  logic [7:0]  byte_in;
  logic        byte_done;
  logic        got_byte;
  logic [3:0]  addr_ptr;
  logic        fixed_mode;
  logic [31:0] key_sr;
  logic [7:0]  ram [16];

  // STB synchroniser resets low so a reset inside a frame never produces a
  // falling edge; decoding resumes only after STB rises and falls again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      stb_sync <= '0;
      dio_sync <= '1;
      clk_q    <= 1'b1;
      stb_q    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], lk_clk};
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], lk_stb};
      dio_sync <= {dio_sync[SYNC_STAGES-2:0], lk_dio_i};
      clk_q    <= clk_s;
      stb_q    <= stb_s;
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign stb_s    = stb_sync[SYNC_STAGES-1];
  assign dio_s    = dio_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_q;
  assign clk_fall = ~clk_s & clk_q;
  assign stb_rise = stb_s & ~stb_q;
  assign stb_fall = ~stb_s & stb_q;

  assign byte_in   = {dio_s, shreg};
  assign byte_done = clk_rise && (bit_cnt[2:0] == 3'd7) &&
                     ((state == CMD) || (state == WDATA));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (stb_rise) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:  if (stb_fall) state_nx = CMD;
        CMD: begin
          if (byte_done) begin
            case (byte_in[7:6])
              2'b01:   state_nx = byte_in[1] ? RDATA : HOLD;
              2'b11:   state_nx = WDATA;
              default: state_nx = HOLD;
            endcase
          end
        end
        RDATA: if (clk_rise && (bit_cnt == 5'd31)) state_nx = HOLD;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      got_byte   <= 1'b0;
      addr_ptr   <= '0;
      fixed_mode <= 1'b0;
      key_sr     <= '0;
      disp_on    <= 1'b0;
      brightness <= '0;
      lk_dio_o   <= 1'b1;
      lk_dio_oe  <= 1'b0;
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
      for (int i = 0; i < 16; i++) ram[i] <= '0;
    end else begin
      frame_done <= stb_rise && got_byte;
      cmd_err    <= 1'b0;
      if (stb_rise) begin
        bit_cnt   <= '0;
        got_byte  <= 1'b0;
        lk_dio_oe <= 1'b0;
        lk_dio_o  <= 1'b1;
      end else begin
        if ((state == IDLE) && stb_fall) begin
          bit_cnt  <= '0;
          got_byte <= 1'b0;
        end
        if (((state == CMD) || (state == WDATA)) && clk_rise) begin
          shreg   <= byte_in[7:1];
          bit_cnt <= bit_cnt + 5'd1;
          if (byte_done) begin
            got_byte <= 1'b1;
            bit_cnt  <= '0;
            if (state == WDATA) begin
              ram[addr_ptr] <= byte_in;
              if (!fixed_mode) addr_ptr <= addr_ptr + 4'd1;
            end else begin
              case (byte_in[7:6])
                2'b01: begin
                  fixed_mode <= byte_in[2];
                  if (byte_in[1]) begin
                    key_sr    <= keys;
                    lk_dio_oe <= 1'b1;
                  end
                end
                2'b11: addr_ptr <= byte_in[3:0];
                2'b10: begin
                  disp_on    <= byte_in[3];
                  brightness <= byte_in[2:0];
                end
                default: cmd_err <= 1'b1;
              endcase
            end
          end
        end
        if (state == RDATA) begin
          if (clk_fall) begin
            lk_dio_o <= key_sr[0];
            key_sr   <= {1'b1, key_sr[31:1]};
          end
          if (clk_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) begin
              lk_dio_oe <= 1'b0;
              lk_dio_o  <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign disp_data = ram[disp_addr];

endmodule
